// File: rtl/tcp_port_demux.sv
// tcp_port_demux: steers one TCP packet at a time to a socket stream selected
// by its destination port. Unmatched packets are drained and counted.

// One table entry: hits only when enabled and the port matches exactly.
module tcp_port_match (
    input  logic [15:0] port,
    input  logic        enable,
    input  logic [15:0] dest,
    output logic        hit
);
    assign hit = enable && (port == dest);
endmodule

module tcp_port_demux #(
    parameter int N_SOCKETS = 4,
    parameter int SW        = (N_SOCKETS > 1) ? $clog2(N_SOCKETS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    s_ip_hdr_valid,
    output logic                    s_ip_hdr_ready,
    input  logic [31:0]             s_ip_source_ip,
    input  logic [15:0]             s_ip_length,
    input  logic [15:0]             i_tcp_dest,
    input  logic                    i_tcp_dest_valid,
    input  logic [7:0]              s_payload_tdata,
    input  logic                    s_payload_tvalid,
    output logic                    s_payload_tready,
    input  logic                    s_payload_tlast,
    input  logic                    s_payload_tuser,
    input  logic [16*N_SOCKETS-1:0] i_port_table,
    input  logic [N_SOCKETS-1:0]    i_port_enable,
    output logic [7:0]              m_tdata,
    output logic                    m_tlast,
    output logic                    m_tuser,
    output logic [N_SOCKETS-1:0]    m_tvalid,
    input  logic [N_SOCKETS-1:0]    m_tready,
    output logic [31:0]             m_src_ip,
    output logic [15:0]             m_length,
    output logic [SW-1:0]           m_sock_idx,
    output logic [15:0]             o_drop_count,
    output logic                    o_busy
);
    typedef enum logic [1:0] {IDLE, WAIT_DEST, FORWARD, DROP} state_t;

    state_t               state, state_nxt;
    logic [N_SOCKETS-1:0] hit;
    logic                 match_any;
    logic [SW-1:0]        match_idx;
    logic [15:0]          drop_count;
    logic                 last_fire;

    genvar k;
    generate
        for (k = 0; k < N_SOCKETS; k++) begin : g_match
            tcp_port_match u_match (
                .port   (i_port_table[16*k +: 16]),
                .enable (i_port_enable[k]),
                .dest   (i_tcp_dest),
                .hit    (hit[k])
            );
        end
    endgenerate

    // Lowest matching index wins: scan downward so lower entries overwrite.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_SOCKETS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_any = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

    // Payload is passed straight through; only the valids are steered.
    assign m_tdata      = s_payload_tdata;
    assign m_tlast      = s_payload_tlast;
    assign m_tuser      = s_payload_tuser;
    assign o_drop_count = drop_count;
    assign o_busy       = (state != IDLE);
    assign last_fire    = s_payload_tvalid && s_payload_tready && s_payload_tlast;

    // Next-state and handshake decode.
    always_comb begin
        state_nxt        = state;
        s_ip_hdr_ready   = 1'b0;
        s_payload_tready = 1'b0;
        m_tvalid         = '0;
        unique case (state)
            IDLE: begin
                s_ip_hdr_ready = 1'b1;
                if (s_ip_hdr_valid) state_nxt = WAIT_DEST;
            end
            WAIT_DEST: begin
                if (i_tcp_dest_valid) state_nxt = match_any ? FORWARD : DROP;
            end
            FORWARD: begin
                s_payload_tready     = m_tready[m_sock_idx];
                m_tvalid[m_sock_idx] = s_payload_tvalid;
                if (last_fire) state_nxt = IDLE;
            end
            DROP: begin
                s_payload_tready = 1'b1;
                if (last_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, per-packet metadata and the saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            m_src_ip   <= '0;
            m_length   <= '0;
            m_sock_idx <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && s_ip_hdr_valid) begin
                m_src_ip <= s_ip_source_ip;
                m_length <= s_ip_length;
            end
            if (state == WAIT_DEST && i_tcp_dest_valid) begin
                if (match_any)
                    m_sock_idx <= match_idx;
                else if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tcp_port_demux.sv
// Randomised bench for tcp_port_demux with a packet-level reference model.
module tb_tcp_port_demux;
    localparam int NS = 4;
    localparam int SW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              s_ip_hdr_valid, s_ip_hdr_ready;
    logic [31:0]       s_ip_source_ip;
    logic [15:0]       s_ip_length;
    logic [15:0]       i_tcp_dest;
    logic              i_tcp_dest_valid;
    logic [7:0]        s_payload_tdata;
    logic              s_payload_tvalid, s_payload_tready, s_payload_tlast, s_payload_tuser;
    logic [16*NS-1:0]  port_table;
    logic [NS-1:0]     port_enable;
    logic [7:0]        m_tdata;
    logic              m_tlast, m_tuser;
    logic [NS-1:0]     m_tvalid, m_tready;
    logic [31:0]       m_src_ip;
    logic [15:0]       m_length;
    logic [SW-1:0]     m_sock_idx;
    logic [15:0]       o_drop_count;
    logic              o_busy;

    int vectors = 0;
    int miscompares = 0;
    int exp_drops = 0;

    tcp_port_demux #(.N_SOCKETS(NS)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
        .s_ip_source_ip(s_ip_source_ip), .s_ip_length(s_ip_length),
        .i_tcp_dest(i_tcp_dest), .i_tcp_dest_valid(i_tcp_dest_valid),
        .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
        .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
        .s_payload_tuser(s_payload_tuser),
        .i_port_table(port_table), .i_port_enable(port_enable),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_src_ip(m_src_ip), .m_length(m_length), .m_sock_idx(m_sock_idx),
        .o_drop_count(o_drop_count), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Drives one packet end to end and checks every cycle against the model.
    // Entered and left just after a falling edge.
    task automatic send_pkt(input logic [31:0] src, input logic [15:0] len,
                            input logic [15:0] dest, input int nbytes,
                            input int bp_mode, input int dest_delay,
                            input bit seq_data, input bit early_hdr,
                            input int abort_after);
        logic [7:0]      bytes [0:255];
        logic [16*NS-1:0] saved_tbl;
        logic [NS-1:0]   saved_en;
        logic [NS-1:0]   exp_tv;
        bit              exp_hit, exp_rdy, acc, tu, tl, pat;
        int              exp_idx, beat, cyc;
        for (int i = 0; i < nbytes; i++) bytes[i] = seq_data ? 8'(i) : 8'($urandom);
        // header
        s_ip_hdr_valid = 1'b1; s_ip_source_ip = src; s_ip_length = len;
        #1 vectors++;
        if ({s_ip_hdr_ready, s_payload_tready, o_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL hdr_accept: got rdy/pay/busy=%b want 100", {s_ip_hdr_ready, s_payload_tready, o_busy});
        end
        @(posedge i_clk); @(negedge i_clk);
        s_ip_hdr_valid = 1'b0; s_ip_source_ip = $urandom; s_ip_length = 16'($urandom);
        // first beat offered early must stall
        s_payload_tvalid = 1'b1; s_payload_tdata = bytes[0]; s_payload_tlast = (nbytes == 1);
        for (int d = 0; d <= dest_delay; d++) begin
            i_tcp_dest_valid = (d == dest_delay);
            i_tcp_dest = (d == dest_delay) ? dest : 16'($urandom);
            if (d == dest_delay) begin
                exp_hit = 1'b0; exp_idx = 0;
                for (int k = 0; k < NS; k++)
                    if (!exp_hit && port_enable[k] && port_table[16*k +: 16] == dest) begin
                        exp_hit = 1'b1; exp_idx = k;
                    end
                if (!exp_hit && exp_drops < 65535) exp_drops++;
            end
            #1 vectors++;
            if ({s_ip_hdr_ready, s_payload_tready, o_busy, m_tvalid} !== {3'b001, 4'b0000}) begin
                miscompares++;
                $display("FAIL wait_dest: got hr/pr/busy/tv=%b want 0010000",
                         {s_ip_hdr_ready, s_payload_tready, o_busy, m_tvalid});
            end
            @(posedge i_clk); @(negedge i_clk);
        end
        i_tcp_dest_valid = 1'b0; i_tcp_dest = 16'($urandom);
        // table changes after lookup must not affect this packet
        saved_tbl = port_table; saved_en = port_enable;
        port_table = {$urandom, $urandom}; port_enable = NS'($urandom);
        beat = 0; cyc = 0;
        while (beat < nbytes && cyc < 500) begin
            if (abort_after >= 0 && beat == abort_after) break;
            pat = (cyc % 4 == 0) || (cyc % 4 == 3);
            case (bp_mode)
                0:       m_tready = '1;
                1:       m_tready = NS'($urandom);
                default: m_tready = {pat, 2'($urandom), 1'b1};
            endcase
            s_payload_tvalid = (bp_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tl = (beat == nbytes - 1); tu = 1'($urandom);
            s_payload_tdata = bytes[beat]; s_payload_tlast = tl; s_payload_tuser = tu;
            if (early_hdr && tl) begin
                s_ip_hdr_valid = 1'b1; s_ip_source_ip = src + 32'd1;
            end
            exp_rdy = exp_hit ? m_tready[exp_idx] : 1'b1;
            exp_tv  = (exp_hit && s_payload_tvalid) ? (NS'(1) << exp_idx) : '0;
            #1 vectors++;
            if ({m_tvalid, s_payload_tready, s_ip_hdr_ready, o_busy} !== {exp_tv, exp_rdy, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL beat%0d handshake: got tv/pr/hr/busy=%b want %b", beat,
                         {m_tvalid, s_payload_tready, s_ip_hdr_ready, o_busy}, {exp_tv, exp_rdy, 1'b0, 1'b1});
            end
            if (exp_hit && s_payload_tvalid) begin
                vectors++;
                if ({m_tdata, m_tlast, m_tuser, m_sock_idx, m_src_ip, m_length} !==
                    {bytes[beat], tl, tu, SW'(exp_idx), src, len}) begin
                    miscompares++;
                    $display("FAIL beat%0d data: got d=%h l=%b u=%b idx=%0d ip=%h len=%0d want d=%h l=%b u=%b idx=%0d ip=%h len=%0d",
                             beat, m_tdata, m_tlast, m_tuser, m_sock_idx, m_src_ip, m_length,
                             bytes[beat], tl, tu, exp_idx, src, len);
                end
            end
            acc = s_payload_tvalid && exp_rdy;
            @(posedge i_clk); @(negedge i_clk);
            if (acc) beat++;
            cyc++;
        end
        s_payload_tvalid = 1'b0;
        if (cyc >= 500) begin
            miscompares++;
            $display("FAIL timeout: packet stalled at beat %0d of %0d", beat, nbytes);
        end
        if (abort_after >= 0 && beat == abort_after) begin
            i_rst = 1'b1;
            @(posedge i_clk); @(negedge i_clk);
            #1 vectors++;
            if ({m_tvalid, o_busy, s_ip_hdr_ready, s_payload_tready, o_drop_count, m_src_ip} !==
                {4'b0000, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0}) begin
                miscompares++;
                $display("FAIL reset_mid_packet: got tv=%b busy=%b hr=%b pr=%b drops=%0d ip=%h want 0000 0 1 0 0 0",
                         m_tvalid, o_busy, s_ip_hdr_ready, s_payload_tready, o_drop_count, m_src_ip);
            end
            i_rst = 1'b0;
            exp_drops = 0;
        end else begin
            #1 vectors++;
            if ({o_busy, s_ip_hdr_ready, s_payload_tready, m_tvalid, o_drop_count} !==
                {3'b010, 4'b0000, 16'(exp_drops)}) begin
                miscompares++;
                $display("FAIL pkt_end: got busy=%b hr=%b pr=%b tv=%b drops=%0d want 0 1 0 0000 drops=%0d",
                         o_busy, s_ip_hdr_ready, s_payload_tready, m_tvalid, o_drop_count, exp_drops);
            end
        end
        port_table = saved_tbl; port_enable = saved_en;
    endtask

    task automatic std_table();
        port_table  = {16'd8080, 16'd22, 16'd443, 16'd80};
        port_enable = 4'b1111;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1 vectors++;
        if ({s_ip_hdr_ready, s_payload_tready, m_tvalid, o_busy, m_src_ip, m_length, m_sock_idx, o_drop_count} !==
            {1'b1, 1'b0, 4'b0000, 1'b0, 32'd0, 16'd0, 2'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset: got hr=%b pr=%b tv=%b busy=%b ip=%h len=%0d idx=%0d drops=%0d",
                     s_ip_hdr_ready, s_payload_tready, m_tvalid, o_busy, m_src_ip, m_length, m_sock_idx, o_drop_count);
        end
        exp_drops = 0;
    endtask

    task automatic test_single_match();
        std_table();
        send_pkt(32'h0A000001, 16'd60, 16'd443, 20, 0, 0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_miss();
        std_table();
        send_pkt(32'h0A000002, 16'd40, 16'd25, 8, 0, 1, 1'b0, 1'b0, -1);
        send_pkt(32'h0A000003, 16'd44, 16'd22, 6, 0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_priority_enable();
        port_table = {16'd0, 16'd0, 16'd80, 16'd80};
        port_enable = 4'b0010;
        send_pkt(32'hC0A80001, 16'd10, 16'd80, 4, 0, 0, 1'b0, 1'b0, -1);
        port_enable = 4'b0011;
        send_pkt(32'hC0A80002, 16'd11, 16'd80, 4, 0, 0, 1'b0, 1'b0, -1);
        port_enable = 4'b0100;
        send_pkt(32'hC0A80003, 16'd12, 16'd0, 3, 0, 0, 1'b0, 1'b0, -1);
        port_enable = 4'b0000;
        send_pkt(32'hC0A80004, 16'd13, 16'd80, 3, 0, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        std_table();
        send_pkt(32'h0B000001, 16'd80, 16'd8080, 20, 2, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        std_table();
        send_pkt(32'h0C000001, 16'd30, 16'd80, 5, 0, 0, 1'b0, 1'b1, -1);
        send_pkt(32'h0C000002, 16'd31, 16'd22, 5, 1, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_packet();
        std_table();
        send_pkt(32'h0D000001, 16'd60, 16'd443, 20, 0, 0, 1'b1, 1'b0, 5);
        send_pkt(32'h0D000002, 16'd61, 16'd443, 20, 0, 0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        pool[0] = 16'd80; pool[1] = 16'd443; pool[2] = 16'd0; pool[3] = 16'd7;
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < NS; k++) port_table[16*k +: 16] = pool[$urandom_range(0, 3)];
            port_enable = NS'($urandom);
            send_pkt($urandom, 16'($urandom), pool[$urandom_range(0, 3)], $urandom_range(1, 10),
                     1, $urandom_range(0, 2), 1'b0, 1'($urandom), -1);
        end
    endtask

    task automatic test_saturation();
        std_table();
        force dut.drop_count = 16'hFFFE;
        #1 release dut.drop_count;
        exp_drops = 65534;
        vectors++;
        if (o_drop_count !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_preload: got %h want fffe", o_drop_count);
        end
        for (int n = 0; n < 3; n++)
            send_pkt(32'h0E000000 + n, 16'd20, 16'd25, 2, 0, 0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        i_rst = 1'b1; s_ip_hdr_valid = 1'b0; s_ip_source_ip = '0; s_ip_length = '0;
        i_tcp_dest = '0; i_tcp_dest_valid = 1'b0; s_payload_tdata = '0;
        s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0; s_payload_tuser = 1'b0;
        port_table = '0; port_enable = '0; m_tready = '1;
        test_reset();
        test_single_match();
        test_miss();
        test_priority_enable();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
